// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the packet-stream arbiter.
//   arb_state_e : arbiter FSM states (idle / grant held)
//   sel_width() : width of the owner index for a given requester count
//   oh2idx()    : index of the set bit in a one-hot vector (up to 16 bits)
package mux_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned oh2idx(input logic [15:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Bundle of the requester-side and shared-output stream signals of mux_arbiter.
//   req_valid/req_data/req_last/req_ready : N requester streams (data packed i*DW +: DW)
//   out_valid/out_data/out_last/out_ready : shared output stream
//   grant/sel/busy/timeout                : arbitration status
// Modports: master = arbiter side, slave = environment side.
interface mux_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned SW = sel_width(N)
);
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic [SW-1:0]   sel;
  logic            busy;
  logic            timeout;

  modport master (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant, sel, busy, timeout
  );

  modport slave (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant, sel, busy, timeout
  );
endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   i_req   : per-requester request vector
//   i_ptr   : round-robin start index (ignored for fixed priority)
//   o_idx   : winner index
//   o_found : at least one request present
// USE_RR != 0 : first requester at or after i_ptr, wrapping modulo N.
// USE_RR == 0 : lowest requesting index.
module arb_pick
  import mux_arb_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned USE_RR = 1,
  parameter int unsigned SW     = sel_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_idx,
  output logic          o_found
);

  logic [N-1:0] w_oh;
  logic         w_found;

  if (USE_RR != 0) begin : g_rr
    always_comb begin
      int unsigned idx;
      w_oh    = '0;
      w_found = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(i_ptr) + k) % N;
        if (!w_found && i_req[idx[SW-1:0]]) begin
          w_oh[idx[SW-1:0]] = 1'b1;
          w_found           = 1'b1;
        end
      end
    end
  end else begin : g_fixed
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
      w_oh    = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        if (!w_found && i_req[k]) begin
          w_oh[k] = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

  assign o_idx   = SW'(oh2idx(16'(w_oh)));
  assign o_found = w_found;

endmodule

// File: rtl/mux_arbiter.sv
// Packet-level arbiter for N streaming requesters onto one shared output.
// A grant is taken in idle (one cycle latency) and held until the owner's last
// beat is accepted; a bubble cycle always separates packets.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_arbiter_if.master (requester streams, shared output, status)
// Optional build macro MUX_ARB_TIMEOUT_EN: revoke a grant after TIMEOUT
// consecutive GRANT cycles without out_valid, pulsing timeout for one cycle.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned USE_RR  = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned SW      = sel_width(N)
) (
  input logic             clk,
  input logic             rst_n,
  mux_arbiter_if.master   bus
);

  arb_state_e    r_state;
  logic [N-1:0]  r_grant;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_ptr;
  logic          r_busy;
  logic          r_timeout;

  logic [SW-1:0] w_pick_idx;
  logic          w_found;
  logic [N-1:0]  w_pick_oh;
  logic [DW-1:0] w_data [N];
  logic          w_own_valid;
  logic          w_own_last;
  logic          w_rel_last;
  logic          w_force;
  logic [SW-1:0] w_ptr_next;

  arb_pick #(
    .N      (N),
    .USE_RR (USE_RR),
    .SW     (SW)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  assign w_pick_oh = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;

  for (genvar g = 0; g < N; g++) begin : g_data
    assign w_data[g] = bus.req_data[g*DW +: DW];
  end

  // r_grant is zero in idle, so masking by it gives both the pass-through and
  // the idle-state zeros without decoding the state.
  assign w_own_valid = |(r_grant & bus.req_valid);
  assign w_own_last  = |(r_grant & bus.req_last);
  assign w_rel_last  = w_own_valid & bus.out_ready & w_own_last;
  assign w_ptr_next  = (32'(r_sel) == N - 1) ? '0 : r_sel + SW'(1);

  assign bus.out_valid = w_own_valid;
  assign bus.out_last  = w_own_last;
  assign bus.out_data  = w_data[r_sel];
  assign bus.req_ready = r_grant & {N{bus.out_ready}};
  assign bus.grant     = r_grant;
  assign bus.sel       = r_sel;
  assign bus.busy      = r_busy;
  assign bus.timeout   = r_timeout;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_idle_cnt;

  // Release on the edge that ends the TIMEOUT-th consecutive idle cycle.
  assign w_force = (r_state == StGrant) && !w_own_valid && (r_idle_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT < 2);
  assign w_force          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_grant   <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      r_idle_cnt <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state <= StGrant;
            r_grant <= w_pick_oh;
            r_sel   <= w_pick_idx;
            r_busy  <= 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
          end
        end
        StGrant: begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (w_own_valid) r_idle_cnt <= '0;
          else             r_idle_cnt <= r_idle_cnt + CW'(1);
`endif
          // sel deliberately keeps the last owner after release.
          if (w_rel_last || w_force) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= w_ptr_next;
            r_timeout <= w_force;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share the
// same stimulus; a per-cycle behavioural model checks both, plus directed cases.
module tb_mux_arbiter;
  import mux_arb_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned SW      = sel_width(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            out_ready = 1'b1;
  logic [N-1:0]    acc       = '0;

  int n_total = 0;
  int n_bad   = 0;

  mux_arbiter_if #(.N(N), .DW(DW)) bus_rr ();
  mux_arbiter_if #(.N(N), .DW(DW)) bus_fp ();

  assign bus_rr.req_valid = req_valid;
  assign bus_rr.req_last  = req_last;
  assign bus_rr.req_data  = req_data;
  assign bus_rr.out_ready = out_ready;
  assign bus_fp.req_valid = req_valid;
  assign bus_fp.req_last  = req_last;
  assign bus_fp.req_data  = req_data;
  assign bus_fp.out_ready = out_ready;

  mux_arbiter #(.N(N), .DW(DW), .USE_RR(1), .TIMEOUT(TIMEOUT)) u_dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  mux_arbiter #(.N(N), .DW(DW), .USE_RR(0), .TIMEOUT(TIMEOUT)) u_dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: owner (-1 = none), last owner index, round-robin pointer, idle run.
  int m_owner [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_idle  [2];
  bit m_to    [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_sel[d]   = 0;
      m_ptr[d]   = 0;
      m_idle[d]  = 0;
      m_to[d]    = 1'b0;
    end
  endtask

  task automatic model_check(input int d, input logic [N-1:0] g, input logic [SW-1:0] s,
                             input logic b, input logic ov, input logic [DW-1:0] od,
                             input logic ol, input logic [N-1:0] rr, input logic to);
    string        p;
    int           o;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         ev;
    p  = (d == 0) ? "rr" : "fp";
    o  = m_owner[d];
    eg = '0;
    er = '0;
    ev = 1'b0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      er[o] = out_ready;
      ev    = req_valid[o];
    end
    chk({p, "_grant"}, 32'(g), 32'(eg));
    chk({p, "_sel"}, 32'(s), 32'(m_sel[d]));
    chk({p, "_busy"}, 32'(b), 32'(o >= 0));
    chk({p, "_timeout"}, 32'(to), 32'(m_to[d]));
    chk({p, "_out_valid"}, 32'(ov), 32'(ev));
    chk({p, "_req_ready"}, 32'(rr), 32'(er));
    if (ev) begin
      chk({p, "_out_data"}, 32'(od), 32'(req_data[o*DW +: DW]));
      chk({p, "_out_last"}, 32'(ol), 32'(req_last[o]));
    end
  endtask

  task automatic model_next(input int d);
    int  o;
    bit  found;
    bit  rel;
    int  i;
    o      = m_owner[d];
    m_to[d] = 1'b0;
    rel    = 1'b0;
    if (o < 0) begin
      found = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        i = (d == 0) ? (m_ptr[d] + k) % int'(N) : k;
        if (!found && req_valid[i]) begin
          found      = 1'b1;
          m_owner[d] = i;
          m_sel[d]   = i;
          m_idle[d]  = 0;
        end
      end
    end else if (req_valid[o] && out_ready && req_last[o]) begin
      rel = 1'b1;
    end else begin
`ifdef MUX_ARB_TIMEOUT_EN
      if (!req_valid[o]) begin
        m_idle[d]++;
        if (m_idle[d] == int'(TIMEOUT)) begin
          rel     = 1'b1;
          m_to[d] = 1'b1;
        end
      end else begin
        m_idle[d] = 0;
      end
`endif
    end
    if (rel) begin
      m_ptr[d]   = (o + 1) % int'(N);
      m_owner[d] = -1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    model_check(0, bus_rr.grant, bus_rr.sel, bus_rr.busy, bus_rr.out_valid, bus_rr.out_data,
                bus_rr.out_last, bus_rr.req_ready, bus_rr.timeout);
    model_check(1, bus_fp.grant, bus_fp.sel, bus_fp.busy, bus_fp.out_valid, bus_fp.out_data,
                bus_fp.out_last, bus_fp.req_ready, bus_fp.timeout);
    if (rst_n) begin
      model_next(0);
      model_next(1);
      acc = req_valid & bus_rr.req_ready;
    end else begin
      acc = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] e;

  initial begin
    model_reset();
    do_reset();

    // Single request: 3 beats from requester 2.
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hA1;
    step(); #1;
    chk("sr_grant", 32'(bus_rr.grant), 32'h4);
    chk("sr_sel", 32'(bus_rr.sel), 32'd2);
    chk("sr_d1", 32'(bus_rr.out_data), 32'hA1);
    step();
    req_data[2*DW +: DW] = 8'hA2;
    #1 chk("sr_d2", 32'(bus_rr.out_data), 32'hA2);
    step();
    req_data[2*DW +: DW] = 8'hA3;
    req_last = 4'b0100;
    #1 chk("sr_d3", 32'(bus_rr.out_data), 32'hA3);
    chk("sr_last", 32'(bus_rr.out_last), 32'd1);
    step();
    idle_inputs();
    #1 chk("sr_busy_drop", 32'(bus_rr.busy), 32'd0);
    req_valid = 4'hF;
    req_last  = 4'hF;
    step(); #1;
    chk("sr_ptr_next", 32'(bus_rr.grant), 32'h8);
    step();
    idle_inputs();
    step();

    // Round-robin fairness: all requesters, one-beat packets.
    do_reset();
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e = '0;
      e[k % 4] = 1'b1;
      step(); #1;
      chk("rr_order", 32'(bus_rr.grant), 32'(e));
      chk("rr_fp_order", 32'(bus_fp.grant), 32'h1);
      step(); #1;
      chk("rr_bubble", 32'(bus_rr.grant), 32'h0);
    end
    idle_inputs();

    // Requesters 1 and 3 continuously valid.
    do_reset();
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("fp_grant", 32'(bus_fp.grant), 32'h2);
      chk("fp_rr_grant", 32'(bus_rr.grant), (k % 2 == 0) ? 32'h2 : 32'h8);
      step();
    end
    idle_inputs();

    // Backpressure: owner 0 sends 2 beats while out_ready toggles 0,1,0,1.
    do_reset();
    req_valid = 4'b0001;
    req_data[0 +: DW] = 8'hB1;
    out_ready = 1'b0;
    step(); #1;
    chk("bp_rdy0", 32'(bus_rr.req_ready), 32'h0);
    step();
    out_ready = 1'b1;
    #1 chk("bp_rdy1", 32'(bus_rr.req_ready), 32'h1);
    chk("bp_d1", 32'(bus_rr.out_data), 32'hB1);
    step();
    req_data[0 +: DW] = 8'hB2;
    req_last  = 4'b0001;
    out_ready = 1'b0;
    #1 chk("bp_rdy2", 32'(bus_rr.req_ready), 32'h0);
    chk("bp_d2", 32'(bus_rr.out_data), 32'hB2);
    step();
    out_ready = 1'b1;
    #1 chk("bp_rdy3", 32'(bus_rr.req_ready), 32'h1);
    step();
    idle_inputs();
    #1 chk("bp_done", 32'(bus_rr.busy), 32'd0);

    // Reset mid-packet, after moving the pointer away from 0.
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    step();
    step();
    req_last = '0;
    req_data[2*DW +: DW] = 8'hC1;
    step();
    step();
    req_data[2*DW +: DW] = 8'hC2;
    rst_n = 1'b0;
    #1;
    chk("rm_grant", 32'(bus_rr.grant), 32'h0);
    chk("rm_busy", 32'(bus_rr.busy), 32'd0);
    chk("rm_valid", 32'(bus_rr.out_valid), 32'd0);
    chk("rm_ready", 32'(bus_rr.req_ready), 32'h0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    step(); #1;
    chk("rm_ptr0", 32'(bus_rr.grant), 32'h2);
    idle_inputs();
    step();
    step();

`ifdef MUX_ARB_TIMEOUT_EN
    // Owner 2 sends one non-last beat, then goes silent; 3 is waiting.
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'hD1;
    step();
    step();
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    repeat (15) step();
    #1 chk("to_held", 32'(bus_rr.busy), 32'd1);
    chk("to_nopulse", 32'(bus_rr.timeout), 32'd0);
    step(); #1;
    chk("to_pulse", 32'(bus_rr.timeout), 32'd1);
    chk("to_release", 32'(bus_rr.grant), 32'h0);
    step(); #1;
    chk("to_next", 32'(bus_rr.grant), 32'h8);
    chk("to_pulse_end", 32'(bus_rr.timeout), 32'd0);
    idle_inputs();
    step();
`endif

    // Randomized traffic; sources hold a beat until the RR arbiter accepts it.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < int'(N); i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i]         = ($urandom_range(0, 3) != 0);
          req_data[i*DW +: DW] = DW'($urandom);
          req_last[i]          = ($urandom_range(0, 2) == 0);
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    idle_inputs();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
